// File: rtl/riscv_csr_pkg.sv
// Shared CSR addresses, access op encodings, mstatus bit positions and trap causes
// for the riscv32i machine-mode CSR file.
package riscv_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  typedef enum logic [1:0] {
    CSR_NOP = 2'b00,
    CSR_RW  = 2'b01,
    CSR_RS  = 2'b10,
    CSR_RC  = 2'b11
  } csr_op_e;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;
  localparam int MIP_MTIP     = 7;

  localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;

  localparam logic [31:0] CAUSE_MTI     = 32'h8000_0007;
  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } redir_state_e;

  function automatic logic [31:0] csr_apply(input logic [1:0]  op,
                                            input logic [31:0] old_v,
                                            input logic [31:0] wdata);
    case (op)
      CSR_RW:  return wdata;
      CSR_RS:  return old_v | wdata;
      CSR_RC:  return old_v & ~wdata;
      default: return old_v;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent 32-bit half writes; 1-cycle update.
// Any half write in a cycle suppresses that cycle's increment for the whole counter.
module csr_counter64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) count_d[31:0]  = wdata_i;
      if (wr_hi_i) count_d[63:32] = wdata_i;
    end else if (inc_i) begin
      count_d = count_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap/mret redirect sequencer; reads are combinational,
// writes commit on the next edge, redirect pulses one cycle after trap/mret.
module csr_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MHARTID     = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_valid_pi,
  input  logic [1:0]  csr_op_pi,
  input  logic [11:0] csr_addr_pi,
  input  logic [31:0] csr_wdata_pi,
  output logic [31:0] csr_rdata_po,
  output logic        csr_illegal_po,
  input  logic        retire_pi,
  input  logic        trap_pi,
  input  logic [31:0] trap_cause_pi,
  input  logic [31:0] trap_pc_pi,
  input  logic        mret_pi,
  input  logic        irq_timer_pi,
  output logic        irq_pending_po,
  output logic        pc_redirect_po,
  output logic [31:0] pc_target_po
);
  import riscv_csr_pkg::*;

  logic         mie_q, mpie_q, mtie_q;
  logic [31:0]  mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic         irq_pending_q;
  redir_state_e state_q;
  logic [31:0]  target_q;
  logic [63:0]  mcycle, minstret;

  logic [31:0] old_val, new_val;
  logic        addr_ok, active, wr_intent, illegal, do_wr;

  always_comb begin
    old_val = '0;
    addr_ok = 1'b1;
    case (csr_addr_pi)
      CSR_MSTATUS:              old_val = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
      CSR_MIE:                  old_val = {24'b0, mtie_q, 7'b0};
      CSR_MTVEC:                old_val = mtvec_q;
      CSR_MSCRATCH:             old_val = mscratch_q;
      CSR_MEPC:                 old_val = mepc_q;
      CSR_MCAUSE:               old_val = mcause_q;
      CSR_MIP:                  old_val = {24'b0, irq_timer_pi, 7'b0};
      CSR_MCYCLE,   CSR_CYCLE:    old_val = mcycle[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:   old_val = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:  old_val = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: old_val = minstret[63:32];
      CSR_MHARTID:              old_val = MHARTID;
      default:                  addr_ok = 1'b0;
    endcase
  end

  // RS/RC with a zero operand is a pure read, so it may target read-only CSRs.
  assign active    = csr_valid_pi && (csr_op_pi != CSR_NOP);
  assign wr_intent = (csr_op_pi == CSR_RW) ||
                     ((csr_op_pi != CSR_NOP) && (csr_wdata_pi != 32'd0));
  assign illegal   = active && (!addr_ok ||
                     (wr_intent && ((csr_addr_pi[11:10] == 2'b11) || (csr_addr_pi == CSR_MIP))));
  assign do_wr     = active && wr_intent && !illegal && !trap_pi && !mret_pi;
  assign new_val   = csr_apply(csr_op_pi, old_val, csr_wdata_pi);

  assign csr_rdata_po   = (active && !illegal) ? old_val : 32'd0;
  assign csr_illegal_po = illegal;

  csr_counter64 u_mcycle (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (1'b1),
    .wr_lo_i (do_wr && (csr_addr_pi == CSR_MCYCLE)),
    .wr_hi_i (do_wr && (csr_addr_pi == CSR_MCYCLEH)),
    .wdata_i (new_val),
    .count_o (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (retire_pi),
    .wr_lo_i (do_wr && (csr_addr_pi == CSR_MINSTRET)),
    .wr_hi_i (do_wr && (csr_addr_pi == CSR_MINSTRETH)),
    .wdata_i (new_val),
    .count_o (minstret)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mie_q      <= MSTATUS_RESET[MSTATUS_MIE];
      mpie_q     <= MSTATUS_RESET[MSTATUS_MPIE];
      mtie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET & ~32'd3;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else if (trap_pi) begin
      mepc_q   <= trap_pc_pi & ~32'd3;
      mcause_q <= trap_cause_pi;
      mpie_q   <= mie_q;
      mie_q    <= 1'b0;
    end else if (mret_pi) begin
      mie_q  <= mpie_q;
      mpie_q <= 1'b1;
    end else if (do_wr) begin
      case (csr_addr_pi)
        CSR_MSTATUS: begin
          mie_q  <= new_val[MSTATUS_MIE];
          mpie_q <= new_val[MSTATUS_MPIE];
        end
        CSR_MIE:      mtie_q     <= new_val[MIE_MTIE];
        CSR_MTVEC:    mtvec_q    <= new_val & ~32'd3;
        CSR_MSCRATCH: mscratch_q <= new_val;
        CSR_MEPC:     mepc_q     <= new_val & ~32'd3;
        CSR_MCAUSE:   mcause_q   <= new_val;
        default: ;
      endcase
    end
  end

  // Any event, even one arriving mid-redirect, (re)arms the pulse with a fresh target.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      target_q      <= '0;
      irq_pending_q <= 1'b0;
    end else begin
      irq_pending_q <= mie_q && mtie_q && irq_timer_pi;
      if (trap_pi) begin
        state_q  <= ST_REDIRECT;
        target_q <= mtvec_q;
      end else if (mret_pi) begin
        state_q  <= ST_REDIRECT;
        target_q <= mepc_q;
      end else begin
        state_q  <= ST_RUN;
      end
    end
  end

  assign pc_redirect_po = (state_q == ST_REDIRECT);
  assign pc_target_po   = target_q;
  assign irq_pending_po = irq_pending_q;

endmodule
